pipe_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage MIPS core. Detects load-use hazards, resolves taken branches in MEM and flushes the younger stages. Freezes the whole pipeline while the data memory is busy, with a bounded timeout. Drives the write-enable and flush/bubble inputs of PC, IF/ID, ID/EX, EX/MEM and MEM/WB, so every pipeline buffer advances only under its control.

---
 rtl/pipe_hazard_ctrl.sv | 157 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: sequencing controller for a 5-stage MIPS pipeline.
// It detects load-use hazards, flushes the younger stages on a branch taken
// in MEM, and freezes the pipeline while data memory is busy. A memory wait
// is bounded by MEM_TIMEOUT frozen cycles.
// Optional feature macro: PIPE_CTRL_PERF_EN enables the saturating stall and
// flush performance counters. Without it both counters read as constant 0.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             mem_branch,
    input  logic             mem_zero,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             idex_we,
    output logic             exmem_we,
    output logic             pc_src,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_flush,
    output logic             memwb_bubble,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_t;

    // The last WAIT count before a forced release
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            mem_err_q, mem_err_d;

    logic to_hit;
    logic freeze;
    logic taken;
    logic load_use;
    logic load_use_eff;

    // Hazard detection, priority resolution and next-state logic
    always_comb begin
        to_hit   = (state_q == WAIT) && (wait_cnt_q == TO_LAST);
        freeze   = dmem_req && !dmem_ready && !to_hit;
        taken    = mem_branch && mem_zero;
        load_use = ex_mem_read && (ex_rd != 5'd0) &&
                   ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
        // A taken branch flushes the dependent instruction, so no stall then
        load_use_eff = load_use && !freeze && !taken;

        state_d    = freeze ? WAIT : RUN;
        wait_cnt_d = (freeze && (state_q == WAIT)) ? (wait_cnt_q + TO_W'(1)) : '0;
        mem_err_d  = mem_err_q || (to_hit && !dmem_ready);
    end

    // Stage enables and flush controls; reset forces every buffer to a NOP
    always_comb begin
        pc_we        = 1'b1;
        ifid_we      = 1'b1;
        idex_we      = 1'b1;
        exmem_we     = 1'b1;
        pc_src       = 1'b0;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_flush  = 1'b0;
        memwb_bubble = 1'b0;
        if (!rst_n) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            idex_we      = 1'b0;
            exmem_we     = 1'b0;
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            exmem_flush  = 1'b1;
            memwb_bubble = 1'b1;
        end else if (freeze) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            idex_we      = 1'b0;
            exmem_we     = 1'b0;
            memwb_bubble = 1'b1;
        end else if (taken) begin
            pc_src      = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b1;
        end else if (load_use_eff) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    // State, wait counter and sticky error registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    assign mem_err = mem_err_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    // Saturating performance counters
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if ((freeze || load_use_eff) && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
        if (taken && !freeze && (flush_q != '1)) begin
            flush_d = flush_q + CNT_W'(1);
        end
    end

    // Counter registers, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scenarios followed by randomized traffic,
// every cycle compared against a cycle-level behavioural model that tracks
// the length of the current memory wait as a plain integer.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

    localparam int TO    = 8;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4:0]       id_rs, id_rt, ex_rd;
    logic             id_uses_rt, ex_mem_read, mem_branch, mem_zero;
    logic             dmem_req, dmem_ready;
    logic             pc_we, ifid_we, idex_we, exmem_we, pc_src;
    logic             ifid_flush, idex_bubble, exmem_flush, memwb_bubble;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_wait_len;   // frozen cycles spent so far on the current access
    bit m_err;
    int m_stall;
    int m_flush;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .TO_W(8), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .mem_branch(mem_branch), .mem_zero(mem_zero),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we), .exmem_we(exmem_we),
        .pc_src(pc_src), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .exmem_flush(exmem_flush), .memwb_bubble(memwb_bubble),
        .mem_err(mem_err), .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model decisions for the current inputs
    function automatic bit m_freeze();
        return dmem_req && !dmem_ready && (m_wait_len < TO);
    endfunction

    function automatic bit m_taken();
        return mem_branch && mem_zero;
    endfunction

    function automatic bit m_hazard();
        return ex_mem_read && (ex_rd != 0) &&
               (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt));
    endfunction

    // Expected {pc_we, ifid_we, idex_we, exmem_we, pc_src,
    //           ifid_flush, idex_bubble, exmem_flush, memwb_bubble}
    function automatic logic [8:0] m_ctrl();
        if (!rst_n)         return 9'b0000_0_1111;
        if (m_freeze())     return 9'b0000_0_0001;
        if (m_taken())      return 9'b1111_1_1110;
        if (m_hazard())     return 9'b0011_0_0100;
        return 9'b1111_0_0000;
    endfunction

    // One clock: compare outputs mid-cycle, then advance the model at the edge
    task automatic cycle();
        logic [8:0] obs;
        bit fz, tk, lu;
        @(negedge clk);
        obs = {pc_we, ifid_we, idex_we, exmem_we, pc_src,
               ifid_flush, idex_bubble, exmem_flush, memwb_bubble};
        check("ctrl", 32'(obs), 32'(m_ctrl()));
        check("mem_err", 32'(mem_err), 32'(m_err));
`ifdef PIPE_CTRL_PERF_EN
        check("stall_cycles", 32'(stall_cycles), 32'(m_stall));
        check("flush_count", 32'(flush_count), 32'(m_flush));
`else
        check("stall_cycles", 32'(stall_cycles), 32'd0);
        check("flush_count", 32'(flush_count), 32'd0);
`endif
        fz = m_freeze();
        tk = m_taken() && !fz;
        lu = m_hazard() && !fz && !tk;
        @(posedge clk);
        if (!rst_n) begin
            m_wait_len = 0;
            m_err      = 0;
            m_stall    = 0;
            m_flush    = 0;
        end else begin
            if (fz) begin
                m_wait_len++;
            end else begin
                if (m_wait_len == TO && !dmem_ready) m_err = 1;
                m_wait_len = 0;
            end
            if ((fz || lu) && m_stall < (1 << CNT_W) - 1) m_stall++;
            if (tk && m_flush < (1 << CNT_W) - 1) m_flush++;
        end
        #1;
    endtask

    task automatic idle_inputs();
        rst_n = 1'b1; id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 1'b1;
        ex_mem_read = 1'b0; ex_rd = 5'd3; mem_branch = 1'b0; mem_zero = 1'b0;
        dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        m_wait_len = 0; m_err = 0; m_stall = 0; m_flush = 0;
        idle_inputs();
        rst_n = 1'b0;
        #1;
        run(3);
        rst_n = 1'b1;
        run(1);
        $display("reset: 3 cycles held, released");

        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs = 5'd5;
        run(1);
        ex_mem_read = 1'b0;
        run(1);
        $display("load-use: ex_rd=5 id_rs=5");

        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs = 5'd0;
        run(1);
        ex_rd = 5'd5; id_rs = 5'd1; id_rt = 5'd5; id_uses_rt = 1'b0;
        run(1);
        $display("load-use: ex_rd=0 and unused rt cases");

        id_uses_rt = 1'b1; id_rs = 5'd5;
        mem_branch = 1'b1; mem_zero = 1'b1;
        run(1);
        idle_inputs();
        run(1);
        $display("taken branch with simultaneous load-use");

        dmem_req = 1'b1; dmem_ready = 1'b0;
        run(4);
        dmem_ready = 1'b1;
        run(1);
        idle_inputs();
        run(1);
        $display("memory wait: 4 not-ready cycles then ready");

        dmem_req = 1'b1; dmem_ready = 1'b0;
        run(TO + 1);
        idle_inputs();
        run(3);
        $display("timeout: ready stuck low for %0d cycles", TO + 1);

        dmem_req = 1'b1; dmem_ready = 1'b0;
        run(2);
        rst_n = 1'b0;
        run(1);
        idle_inputs();
        run(2);
        $display("reset asserted during WAIT");

        // Randomized traffic with phases of slow memory to reach timeouts
        for (int i = 0; i < 3000; i++) begin
            bit slow;
            slow        = ((i / 200) % 2) == 1;
            rst_n       = ($urandom_range(0, 99) != 0);
            id_rs       = 5'($urandom_range(0, 3));
            id_rt       = 5'($urandom_range(0, 3));
            id_uses_rt  = 1'($urandom);
            ex_mem_read = 1'($urandom);
            ex_rd       = 5'($urandom_range(0, 3));
            mem_branch  = ($urandom_range(0, 4) == 0);
            mem_zero    = 1'($urandom);
            dmem_req    = slow ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 2) == 0);
            dmem_ready  = slow ? ($urandom_range(0, 11) == 0) : 1'($urandom);
            cycle();
        end
        $display("random: 3000 cycles of mixed traffic");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
